// File: rtl/time_surface_pkg.sv
// Shared types and default geometry for the time-surface scan path.
package time_surface_pkg;

    localparam int DEF_GRID_SIZE  = 32;
    localparam int NUM_CELLS      = DEF_GRID_SIZE * DEF_GRID_SIZE;
    localparam int DEF_ADDR_BITS  = 10;
    localparam int DEF_VALUE_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

    // Shape of one streamed feature at the default geometry.
    typedef struct packed {
        logic [DEF_ADDR_BITS-1:0]  addr;
        logic [DEF_VALUE_BITS-1:0] data;
        logic                      last;
    } feat_t;

endpackage

// File: rtl/scan_feature_fifo.sv
// Small synchronous FIFO holding returned features ahead of the valid/ready port.
module scan_feature_fifo
    import time_surface_pkg::*;
#(
    parameter type T     = feat_t,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           push,
    input  T               wr_data,
    input  logic           pop,
    output T               rd_data,
    output logic           empty,
    output logic [PTR_W:0] count
);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Upstream credit accounting must make an overflowing write impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/time_surface_scanner.sv
// Sweeps every encoder cell in address order, streams values out with credit-based
// read issue, and accumulates per-frame sum / max / non-zero count.
module time_surface_scanner
    import time_surface_pkg::*;
#(
    parameter int GRID_SIZE    = DEF_GRID_SIZE,
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int VALUE_BITS   = DEF_VALUE_BITS,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          ts_read_enable,
    output logic [ADDR_BITS-1:0]          ts_read_addr,
    input  logic [VALUE_BITS-1:0]         ts_read_value,
    output logic                          feat_valid,
    input  logic                          feat_ready,
    output logic [VALUE_BITS-1:0]         feat_data,
    output logic [ADDR_BITS-1:0]          feat_addr,
    output logic                          feat_last,
    output logic [VALUE_BITS+ADDR_BITS-1:0] frame_sum,
    output logic [VALUE_BITS-1:0]         frame_max,
    output logic [ADDR_BITS:0]            frame_active,
    output logic                          stats_valid
);

    localparam int N_CELLS = GRID_SIZE * GRID_SIZE;
    localparam int SUM_W   = VALUE_BITS + ADDR_BITS;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 2;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N_CELLS - 1);

    typedef struct packed {
        logic [ADDR_BITS-1:0]  addr;
        logic [VALUE_BITS-1:0] data;
        logic                  last;
    } feat_entry_t;

    scan_state_t state, state_next;

    logic [ADDR_BITS-1:0]                         issue_addr;
    logic [READ_LATENCY-1:0]                      vld_pipe;
    logic [READ_LATENCY-1:0][ADDR_BITS-1:0]       addr_pipe;
    logic [CNT_W-1:0]                             inflight;
    logic [PTR_W:0]                               fifo_count;
    logic                                         fifo_empty;
    feat_entry_t                                  push_entry, head;
    logic                                         start_ok, issue, last_issue, push, pop, last_hs;
    logic [SUM_W-1:0]                             acc_sum;
    logic [VALUE_BITS-1:0]                        acc_max;
    logic [ADDR_BITS:0]                           acc_active;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CNT_W'(vld_pipe[i]);
    end

    // Credits count both buffered and still-returning reads, so a push always has room.
    assign start_ok   = (state == IDLE) && start;
    assign issue      = (state == SCAN) && ((CNT_W'(fifo_count) + inflight) < CNT_W'(FIFO_DEPTH));
    assign last_issue = issue && (issue_addr == LAST_ADDR);
    assign push       = vld_pipe[READ_LATENCY-1];
    assign pop        = feat_valid && feat_ready;
    assign last_hs    = pop && head.last;

    assign push_entry.addr = addr_pipe[READ_LATENCY-1];
    assign push_entry.data = ts_read_value;
    assign push_entry.last = (addr_pipe[READ_LATENCY-1] == LAST_ADDR);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = SCAN;
            SCAN:    if (last_issue) state_next = DRAIN;
            DRAIN:   if (last_hs)    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            issue_addr   <= '0;
            vld_pipe     <= '0;
            addr_pipe    <= '0;
            acc_sum      <= '0;
            acc_max      <= '0;
            acc_active   <= '0;
            frame_sum    <= '0;
            frame_max    <= '0;
            frame_active <= '0;
            done         <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == DRAIN) && last_hs;
            if (start_ok) begin
                issue_addr <= '0;
                acc_sum    <= '0;
                acc_max    <= '0;
                acc_active <= '0;
            end else begin
                if (issue && !last_issue) issue_addr <= issue_addr + 1'b1;
                if (push) begin
                    acc_sum    <= acc_sum + SUM_W'(ts_read_value);
                    acc_active <= acc_active + (ADDR_BITS+1)'(ts_read_value != '0);
                    if (ts_read_value > acc_max) acc_max <= ts_read_value;
                end
            end
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
            vld_pipe[0]  <= issue;
            addr_pipe[0] <= issue_addr;
            // The last push always lands before the last pop, so accumulators are final here.
            if ((state == DRAIN) && last_hs) begin
                frame_sum    <= acc_sum;
                frame_max    <= acc_max;
                frame_active <= acc_active;
            end
        end
    end

    scan_feature_fifo #(
        .T     (feat_entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_ok),
        .push    (push),
        .wr_data (push_entry),
        .pop     (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign busy           = (state != IDLE);
    assign stats_valid    = done;
    assign ts_read_enable = issue;
    assign ts_read_addr   = issue_addr;
    assign feat_valid     = !fifo_empty;
    // Head storage is not reset; mask it so idle outputs read as zero.
    assign feat_data      = feat_valid ? head.data : '0;
    assign feat_addr      = feat_valid ? head.addr : '0;
    assign feat_last      = feat_valid && head.last;

endmodule

// File: tb/tb_time_surface_scanner.sv
// Scoreboard bench for time_surface_scanner on a 4x4 grid with a latency-2 encoder model.
module tb_time_surface_scanner;

    localparam int GS = 4, AB = 4, VB = 8, RL = 2, FD = 4, NC = GS * GS;

    logic              clk = 1'b0, rst_n = 1'b1, start = 1'b0, feat_ready = 1'b1;
    logic              busy, done, ts_read_enable, feat_valid, feat_last, stats_valid;
    logic [AB-1:0]     ts_read_addr, feat_addr;
    logic [VB-1:0]     ts_read_value, feat_data, frame_max;
    logic [VB+AB-1:0]  frame_sum;
    logic [AB:0]       frame_active;

    int checks = 0, errors = 0;
    int rd_next, rd_pulses, outstanding, max_out, gaps, done_cnt;
    logic [AB+VB:0] sb[$];
    logic [AB+VB:0] prev_word;
    bit  hold_prev = 0;
    bit  zero_mode = 0;
    logic [VB-1:0] r1 = '0, r2 = '0;

    always #5 clk = ~clk;

    time_surface_scanner #(
        .GRID_SIZE(GS), .ADDR_BITS(AB), .VALUE_BITS(VB), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .ts_read_enable(ts_read_enable), .ts_read_addr(ts_read_addr), .ts_read_value(ts_read_value),
        .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_data(feat_data),
        .feat_addr(feat_addr), .feat_last(feat_last), .frame_sum(frame_sum),
        .frame_max(frame_max), .frame_active(frame_active), .stats_valid(stats_valid)
    );

    function automatic logic [VB-1:0] enc_val(input logic [AB-1:0] a);
        return zero_mode ? 8'h00 : 8'(a * 16);
    endfunction

    // Encoder: value for a strobed address appears RL cycles later; filler otherwise.
    always @(posedge clk) begin
        r1 <= ts_read_enable ? enc_val(ts_read_addr) : 8'hA5;
        r2 <= r1;
    end
    assign ts_read_value = r2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        logic [AB+VB:0] w;
        @(negedge clk);
        if (!rst_n) begin hold_prev = 0; continue; end
        if (hold_prev) chk("stable", {feat_valid, feat_addr, feat_data, feat_last}, {1'b1, prev_word});
        if (ts_read_enable) begin
            chk("rd_addr", 32'(ts_read_addr), rd_next);
            rd_next++; rd_pulses++; outstanding++;
        end else if (rd_next > 0 && rd_next < NC) begin
            gaps++;
        end
        if (feat_valid && feat_ready) begin
            outstanding--;
            if (sb.size() == 0) chk("extra_feat", 32'(sb.size()), 1);
            else begin
                w = sb.pop_front();
                chk("feat_addr", 32'(feat_addr), 32'(w[AB+VB:VB+1]));
                chk("feat_data", 32'(feat_data), 32'(w[VB:1]));
                chk("feat_last", 32'(feat_last), 32'(w[0]));
            end
        end
        if (outstanding > max_out) max_out = outstanding;
        if (done) begin
            done_cnt++;
            chk("stats_valid", 32'(stats_valid), 1);
        end
        hold_prev = feat_valid && !feat_ready;
        prev_word = {feat_addr, feat_data, feat_last};
    end

    task automatic zero_outputs(input string pfx);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_done"}, 32'(done), 0);
        chk({pfx, "_rd_en"}, 32'(ts_read_enable), 0);
        chk({pfx, "_rd_addr"}, 32'(ts_read_addr), 0);
        chk({pfx, "_fvalid"}, 32'(feat_valid), 0);
        chk({pfx, "_fword"}, 32'({feat_addr, feat_data, feat_last}), 0);
        chk({pfx, "_sum"}, 32'(frame_sum), 0);
        chk({pfx, "_max"}, 32'(frame_max), 0);
        chk({pfx, "_active"}, 32'(frame_active), 0);
        chk({pfx, "_svalid"}, 32'(stats_valid), 0);
    endtask

    // mode 0: ready high, 1: ready low cycles 3..12, 2: random ready
    task automatic run_scan(input int mode, input int restart_at, input int reset_at,
                            input bit zero, output int lat);
        int n, exp_sum, exp_max, exp_act;
        bit seen;
        logic [VB-1:0] v;
        zero_mode = zero;
        sb.delete();
        rd_next = 0; rd_pulses = 0; outstanding = 0; max_out = 0; gaps = 0; done_cnt = 0;
        exp_sum = 0; exp_max = 0; exp_act = 0;
        for (int i = 0; i < NC; i++) begin
            v = enc_val(AB'(i));
            sb.push_back({AB'(i), v, i == NC - 1});
            exp_sum += int'(v);
            if (int'(v) > exp_max) exp_max = int'(v);
            if (v != 0) exp_act++;
        end
        feat_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        n = 0; seen = 0; lat = -1;
        while (n < 200 && !seen) begin
            @(posedge clk); n++; #1;
            start = (n == restart_at);
            case (mode)
                1:       feat_ready = !(n >= 3 && n <= 12);
                2:       feat_ready = 1'($urandom_range(0, 1));
                default: feat_ready = 1'b1;
            endcase
            if (n == reset_at) begin
                rst_n = 1'b0;
                #1 zero_outputs("midrst");
                sb.delete();
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (30) @(posedge clk);
                #1 chk("midrst_no_done", done_cnt, 0);
                chk("midrst_idle", 32'(busy), 0);
                return;
            end
            @(negedge clk);
            if (done) begin
                seen = 1; lat = n;
                chk("frame_sum", 32'(frame_sum), exp_sum);
                chk("frame_max", 32'(frame_max), exp_max);
                chk("frame_active", 32'(frame_active), exp_act);
                chk("busy_at_done", 32'(busy), 0);
            end
        end
        if (!seen) chk("timeout_done", 0, 1);
        start = 1'b0; feat_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("done_count", done_cnt, 1);
        chk("sb_left", sb.size(), 0);
        chk("rd_pulses", rd_pulses, NC);
        chk("sum_held", 32'(frame_sum), exp_sum);
        chk("svalid_low", 32'(stats_valid), 0);
    endtask

    initial begin
        int lat;
        #2 rst_n = 1'b0;
        #2 zero_outputs("rst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_scan(0, -1, -1, 0, lat);
        chk("latency_full", lat, NC + RL + 2);
        chk("gaps_full", gaps, 0);

        run_scan(1, -1, -1, 0, lat);
        chk("max_outstanding_bp", max_out, FD);
        chk("issue_stalled_bp", 32'(gaps > 0), 1);

        run_scan(2, -1, -1, 0, lat);

        run_scan(0, 5, -1, 0, lat);
        chk("latency_restart", lat, NC + RL + 2);

        run_scan(0, -1, 8, 0, lat);
        run_scan(0, -1, -1, 0, lat);
        chk("latency_after_rst", lat, NC + RL + 2);

        run_scan(0, -1, -1, 1, lat);
        chk("latency_zero", lat, NC + RL + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_surface_scanner.md
Name: time_surface_scanner

Overview:
- Downstream feature-scan stage for time_surface_encoder.
- On a start pulse it sweeps every grid cell in address order through the encoder's read port and streams the decayed values out on a valid/ready interface for the classifier.
- It also produces per-frame statistics: sum, max and non-zero count.
- A small output FIFO plus credit-based read issue absorbs the encoder's fixed read latency under backpressure.

Parameters:
- GRID_SIZE, 32, grid dimension; NUM_CELLS = GRID_SIZE*GRID_SIZE.
- ADDR_BITS, 10, log2(NUM_CELLS).
- VALUE_BITS, 8, surface value width.
- READ_LATENCY, 2, cycles from read issue to read_value valid; must be ≥1.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, ≥ READ_LATENCY+1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to scan one frame.
- busy  out  1  high from accepted start until the last feature handshake.
- done  out  1  one-cycle pulse on the cycle after the last feature handshake.
- ts_read_enable  out  1  read strobe to the encoder.
- ts_read_addr  out  ADDR_BITS  cell address to the encoder.
- ts_read_value  in  VALUE_BITS  decayed value, valid READ_LATENCY cycles after the strobe.
- feat_valid  out  1  feature available.
- feat_ready  in  1  downstream accepts.
- feat_data  out  VALUE_BITS  cell value.
- feat_addr  out  ADDR_BITS  cell index.
- feat_last  out  1  marks cell NUM_CELLS-1.
- frame_sum  out  VALUE_BITS+ADDR_BITS  sum of all cell values of the last completed frame.
- frame_max  out  VALUE_BITS  maximum cell value of the last completed frame.
- frame_active  out  ADDR_BITS+1  count of non-zero cells.
- stats_valid  out  1  pulse coincident with done; stats held until the next done.

Behaviour:
- Reset (async assert, sync deassert): FSM in IDLE. All of the following are 0: busy, done, ts_read_enable, ts_read_addr, feat_valid, feat_data, feat_addr, feat_last, frame_sum, frame_max, frame_active, stats_valid. FIFO empty, in-flight pipe cleared, accumulators cleared.
- FSM states:
  - IDLE: start → SCAN; clears issue address, accumulators and FIFO pointers; busy rises next cycle.
  - SCAN: issues reads; after issuing address NUM_CELLS-1 → DRAIN.
  - DRAIN: no reads; waits until the in-flight pipe and FIFO are empty and the last feature has handshaken → IDLE, pulsing done and stats_valid.
- start while busy is ignored (no restart, no queueing).
- Read issue:
  - ts_read_enable=1 for exactly one cycle per address, only when fifo_count + inflight_count < FIFO_DEPTH.
  - Addresses are strictly increasing, 0..NUM_CELLS-1, with no gaps or repeats.
  - ts_read_enable=0 in IDLE and DRAIN; ts_read_addr holds its last value when not strobing.
- In-flight tracking:
  - READ_LATENCY-deep shift register of {valid, addr}.
  - When the tail valid bit is set, ts_read_value and its addr are written to the FIFO that cycle.
  - The credit rule guarantees the write never finds the FIFO full. A write into a full FIFO is an assertion failure, never a drop.
- Output:
  - feat_* driven from the FIFO head.
  - feat_valid = FIFO non-empty; pop on feat_valid & feat_ready.
  - feat_data, feat_addr and feat_last remain stable while feat_valid & !feat_ready.
  - Simultaneous push and pop in the same cycle leaves the count unchanged.
- Statistics:
  - Updated on each FIFO push, not on pop.
  - sum += value; max = max(max, value); active += (value != 0).
  - Committed to frame_* on the done cycle.
  - frame_sum width covers NUM_CELLS*255 with no overflow; frame_active reaches NUM_CELLS exactly.
- Throughput: with feat_ready held high, one feature per cycle after the initial READ_LATENCY fill. start-to-done = NUM_CELLS + READ_LATENCY + 2 cycles.
- Reset mid-scan: everything returns to reset values immediately; no done pulse; partial statistics are discarded.

Decomposition:
- Shared package time_surface_pkg holds:
  - NUM_CELLS constant.
  - scan_state_t enum {IDLE, SCAN, DRAIN}.
  - feat_t struct {addr, data, last}.
- One sub-module, scan_feature_fifo:
  - Parameterised synchronous FIFO of feat_t with count output.
  - Same clk and rst_n.
- The FSM, credit logic, in-flight pipe and accumulators live in the top.

Test Plan:
- Setup: GRID_SIZE=4 (16 cells), READ_LATENCY=2, FIFO_DEPTH=4. Model the encoder returning value = 16*addr mod 256.
- Full scan, ready always high:
  - Features addr 0..15, data 0,16,…,240, feat_last only on addr 15.
  - done 20 cycles after start.
  - frame_sum=1920, frame_max=240, frame_active=15.
- Backpressure: feat_ready low cycles 3–12 after start:
  - At most 4 reads outstanding+buffered; ts_read_enable deasserts.
  - feat_data stable while stalled.
  - No value lost or duplicated; same stats as the full scan.
- Random feat_ready (50%):
  - Output sequence identical to the reference list 0..15.
  - Counting ts_read_enable pulses gives exactly 16.
- start pulsed again at cycle 5 while busy:
  - Ignored; exactly one done; addresses not restarted.
- rst_n asserted at cycle 8 of a scan:
  - All outputs 0 asynchronously; no done.
  - A fresh start afterwards produces a clean full scan with correct stats.
- All-zero surface:
  - frame_sum=0, frame_max=0, frame_active=0.
  - stats_valid coincident with done.
